// File: rtl/acc_sequencer.sv
// Multi-cycle control FSM for the 11-bit accumulator datapath.
// It steps through fetch, decode, memory operand and execute phases, and
// counts every instruction it completes.
module acc_sequencer #(
  parameter int OPCODE_W = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                acc_zero,
  input  logic                acc_neg,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                addr_sel,
  output logic                ir_wr,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                acc_wr,
  output logic                acc_reset,
  output logic [2:0]          alu_op,
  output logic                opnd_sel,
  output logic                busy,
  output logic                halted,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, MEM_RD, MEM_WR, EXEC, HALT
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_CLR  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_JZ   = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_JN   = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(15);

  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_OR     = 3'd4;
  localparam logic [2:0] ALU_XOR    = 3'd5;
  localparam logic [2:0] ALU_NOT_A  = 3'd6;

  state_t              state, state_next;
  logic [OPCODE_W-1:0] op_q;
  logic                retire;

  // State register, latched opcode and retired-instruction counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_q    <= '0;
      retired <= '0;
    end else begin
      state <= state_next;
      if (state == DECODE)
        op_q <= opcode;
      if (retire)
        retired <= retired + CNT_W'(1);
    end
  end

  // Next-state, retire and control strobes, decoded from state and op_q.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    ir_wr      = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_wr     = 1'b0;
    acc_reset  = 1'b0;
    alu_op     = ALU_PASS_B;
    opnd_sel   = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = FETCH;
      end
      FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr      = 1'b1;
          pc_inc     = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        busy = 1'b1;
        case (opcode)
          OP_NOP: begin
            retire     = 1'b1;
            state_next = FETCH;
          end
          OP_HLT: begin
            retire     = 1'b1;
            state_next = HALT;
          end
          OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
            state_next = MEM_RD;
          OP_ST:
            state_next = MEM_WR;
          OP_NOT, OP_CLR, OP_JMP, OP_JZ, OP_JN, OP_LDI, OP_ADDI:
            state_next = EXEC;
          default: begin
            illegal_op = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEM_RD: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready)
          state_next = EXEC;
      end
      MEM_WR: begin
        busy     = 1'b1;
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      EXEC: begin
        busy       = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
        case (op_q)
          OP_LD:   begin acc_wr = 1'b1; alu_op = ALU_PASS_B; end
          OP_ADD:  begin acc_wr = 1'b1; alu_op = ALU_ADD;    end
          OP_SUB:  begin acc_wr = 1'b1; alu_op = ALU_SUB;    end
          OP_AND:  begin acc_wr = 1'b1; alu_op = ALU_AND;    end
          OP_OR:   begin acc_wr = 1'b1; alu_op = ALU_OR;     end
          OP_XOR:  begin acc_wr = 1'b1; alu_op = ALU_XOR;    end
          OP_NOT:  begin acc_wr = 1'b1; alu_op = ALU_NOT_A;  end
          OP_CLR:  acc_reset = 1'b1;
          OP_LDI:  begin acc_wr = 1'b1; alu_op = ALU_PASS_B; opnd_sel = 1'b1; end
          OP_ADDI: begin acc_wr = 1'b1; alu_op = ALU_ADD;    opnd_sel = 1'b1; end
          OP_JMP:  pc_load = 1'b1;
          OP_JZ:   pc_load = acc_zero;
          OP_JN:   pc_load = acc_neg;
          default: ;
        endcase
      end
      HALT: begin
        halted = 1'b1;
        if (start)
          state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: expected per-cycle outputs are queued as
// each step is driven and popped when the DUT outputs are sampled.
module tb_acc_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [4:0]  opcode;
  logic        mem_ready;
  logic        acc_zero;
  logic        acc_neg;
  logic        mem_rd, mem_wr, addr_sel, ir_wr, pc_inc, pc_load;
  logic        acc_wr, acc_reset, opnd_sel, busy, halted, illegal_op;
  logic [2:0]  alu_op;
  logic [15:0] retired;

  typedef struct {
    string       tag;
    logic [14:0] outs;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          compared;
  int          mismatched;
  logic [15:0] exp_ret;
  logic [14:0] dut_outs;

  acc_sequencer #(.OPCODE_W(5), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .mem_ready(mem_ready), .acc_zero(acc_zero), .acc_neg(acc_neg),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel), .ir_wr(ir_wr),
    .pc_inc(pc_inc), .pc_load(pc_load), .acc_wr(acc_wr),
    .acc_reset(acc_reset), .alu_op(alu_op), .opnd_sel(opnd_sel),
    .busy(busy), .halted(halted), .illegal_op(illegal_op),
    .retired(retired)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign dut_outs = {mem_rd, mem_wr, addr_sel, ir_wr, pc_inc, pc_load,
                     acc_wr, acc_reset, alu_op, opnd_sel, busy, halted,
                     illegal_op};

  function automatic logic [14:0] ov(input logic rd, wr, as, irw, pci, pcl,
                                     aw, ar, input logic [2:0] op,
                                     input logic os, bz, hl, il);
    return {rd, wr, as, irw, pci, pcl, aw, ar, op, os, bz, hl, il};
  endfunction

  function automatic logic [14:0] o_idle();
    return '0;
  endfunction
  function automatic logic [14:0] o_fetch(input logic rdy);
    return ov(1, 0, 0, rdy, rdy, 0, 0, 0, 3'd0, 0, 1, 0, 0);
  endfunction
  function automatic logic [14:0] o_decode(input logic ill);
    return ov(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, ill);
  endfunction
  function automatic logic [14:0] o_memrd();
    return ov(1, 0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0);
  endfunction
  function automatic logic [14:0] o_memwr();
    return ov(0, 1, 1, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0);
  endfunction
  function automatic logic [14:0] o_exec(input logic pcl, aw, ar,
                                         input logic [2:0] op, input logic os);
    return ov(0, 0, 0, 0, 0, pcl, aw, ar, op, os, 1, 0, 0);
  endfunction
  function automatic logic [14:0] o_halt();
    return ov(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1, 0);
  endfunction

  // Queue the expectation for the current cycle, check it before the next
  // rising edge, then advance past that edge.
  task automatic applyStimulus(input string tag, input logic [14:0] outs);
    exp_t e;
    e.tag  = tag;
    e.outs = outs;
    e.ret  = exp_ret;
    sb.push_back(e);
    @(negedge clock);
    checkOutput();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    compared++;
    assert (dut_outs === e.outs) else begin
      mismatched++;
      $error("[TB] FAIL %s outputs: observed %b expected %b", e.tag, dut_outs, e.outs);
    end
    compared++;
    assert (retired === e.ret) else begin
      mismatched++;
      $error("[TB] FAIL %s retired: observed %0d expected %0d", e.tag, retired, e.ret);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_ret    = '0;
    reset_n    = 1'b0;
    start      = 1'b0;
    opcode     = 5'd0;
    mem_ready  = 1'b0;
    acc_zero   = 1'b0;
    acc_neg    = 1'b0;

    applyStimulus("reset_held", o_idle());
    reset_n = 1'b1;
    applyStimulus("idle_no_start", o_idle());
    start = 1'b1;
    applyStimulus("idle_start", o_idle());
    start     = 1'b0;
    mem_ready = 1'b1;

    // LDI: fetch, decode, exec (3 cycles)
    opcode = 5'd13;
    applyStimulus("ldi_fetch", o_fetch(1));
    applyStimulus("ldi_decode", o_decode(0));
    applyStimulus("ldi_exec", o_exec(0, 1, 0, 3'd0, 1));
    exp_ret++;

    // ADD with three memory wait cycles in MEM_RD (7 cycles)
    opcode = 5'd3;
    applyStimulus("add_fetch", o_fetch(1));
    applyStimulus("add_decode", o_decode(0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      applyStimulus("add_memrd_wait", o_memrd());
    mem_ready = 1'b1;
    applyStimulus("add_memrd_ready", o_memrd());
    applyStimulus("add_exec", o_exec(0, 1, 0, 3'd1, 0));
    exp_ret++;

    // Conditional jumps, taken and not taken
    opcode   = 5'd11;
    acc_zero = 1'b1;
    applyStimulus("jz_fetch", o_fetch(1));
    applyStimulus("jz_decode", o_decode(0));
    applyStimulus("jz_taken", o_exec(1, 0, 0, 3'd0, 0));
    exp_ret++;
    acc_zero = 1'b0;
    applyStimulus("jz2_fetch", o_fetch(1));
    applyStimulus("jz2_decode", o_decode(0));
    applyStimulus("jz_not_taken", o_exec(0, 0, 0, 3'd0, 0));
    exp_ret++;
    opcode  = 5'd12;
    acc_neg = 1'b1;
    applyStimulus("jn_fetch", o_fetch(1));
    applyStimulus("jn_decode", o_decode(0));
    applyStimulus("jn_taken", o_exec(1, 0, 0, 3'd0, 0));
    exp_ret++;
    acc_neg = 1'b0;
    applyStimulus("jn2_fetch", o_fetch(1));
    applyStimulus("jn2_decode", o_decode(0));
    applyStimulus("jn_not_taken", o_exec(0, 0, 0, 3'd0, 0));
    exp_ret++;

    // CLR and NOT in EXEC
    opcode = 5'd9;
    applyStimulus("clr_fetch", o_fetch(1));
    applyStimulus("clr_decode", o_decode(0));
    applyStimulus("clr_exec", o_exec(0, 0, 1, 3'd0, 0));
    exp_ret++;
    opcode = 5'd8;
    applyStimulus("not_fetch", o_fetch(1));
    applyStimulus("not_decode", o_decode(0));
    applyStimulus("not_exec", o_exec(0, 1, 0, 3'd6, 0));
    exp_ret++;

    // NOP retires from DECODE (2 cycles)
    opcode = 5'd0;
    applyStimulus("nop_fetch", o_fetch(1));
    applyStimulus("nop_decode", o_decode(0));
    exp_ret++;

    // Illegal opcode: one-cycle pulse, retire, back to FETCH
    opcode = 5'd20;
    applyStimulus("ill_fetch", o_fetch(1));
    applyStimulus("ill_decode", o_decode(1));
    exp_ret++;

    // HLT then restart
    opcode = 5'd15;
    applyStimulus("hlt_fetch", o_fetch(1));
    applyStimulus("hlt_decode", o_decode(0));
    exp_ret++;
    applyStimulus("halt_wait", o_halt());
    start = 1'b1;
    applyStimulus("halt_start", o_halt());
    start = 1'b0;

    // ST, then async reset while MEM_WR waits on memory
    opcode = 5'd2;
    applyStimulus("st_fetch", o_fetch(1));
    applyStimulus("st_decode", o_decode(0));
    mem_ready = 1'b0;
    applyStimulus("st_memwr_wait", o_memwr());
    #2;
    reset_n = 1'b0;
    #1;
    exp_ret = '0;
    compared++;
    assert (dut_outs === o_idle()) else begin
      mismatched++;
      $error("[TB] FAIL async_reset outputs: observed %b expected %b", dut_outs, o_idle());
    end
    compared++;
    assert (retired === exp_ret) else begin
      mismatched++;
      $error("[TB] FAIL async_reset retired: observed %0d expected %0d", retired, exp_ret);
    end
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    applyStimulus("post_reset_idle1", o_idle());
    applyStimulus("post_reset_idle2", o_idle());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Multi-cycle control FSM for the 11-bit accumulator datapath.
- Fetches an instruction, decodes its opcode, and reads or writes a memory operand over a ready handshake.
- Drives the accumulator's acc_wr/acc_reset, ALU op select, operand select, and the PC controls.
- Sits between the instruction register, the data memory port and the accumulator/ALU.

Parameters:
- OPCODE_W, 5, width of the opcode field taken from the instruction register.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE or HALT and begins fetching.
- opcode  in  OPCODE_W  opcode field from the external IR.
- mem_ready  in  1  memory completes the current rd/wr this cycle.
- acc_zero  in  1  acc_out == 0.
- acc_neg  in  1  acc_out[10].
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request (write data = acc_out).
- addr_sel  out  1  0 = PC address, 1 = operand address.
- ir_wr  out  1  load the IR from memory data.
- pc_inc  out  1  PC += 1.
- pc_load  out  1  PC <= operand (jump taken).
- acc_wr  out  1  accumulator write enable.
- acc_reset  out  1  accumulator clear.
- alu_op  out  3  0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT_A.
- opnd_sel  out  1  ALU B source: 0 = memory data, 1 = immediate.
- busy  out  1  state is neither IDLE nor HALT.
- halted  out  1  state is HALT.
- illegal_op  out  1  one-cycle pulse when an undefined opcode is decoded.
- retired  out  CNT_W  count of completed instructions; wraps to 0.

Behaviour:
- Reset (async, reset_n = 0):
  - State goes to IDLE; op_q = 0; retired = 0.
  - Every output is 0.
  - Reset mid-instruction abandons the instruction with no retire and no pending strobe.
- Outputs are decoded from state and op_q. Strobes qualified "on mem_ready" are combinational with mem_ready in the same cycle.
- Opcodes:
  - 0 NOP, 1 LD, 2 ST, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 CLR.
  - 10 JMP, 11 JZ, 12 JN, 13 LDI, 14 ADDI, 15 HLT.
  - 16..31 are illegal.
- States:
  - IDLE: start -> FETCH.
  - FETCH: mem_rd = 1, addr_sel = 0. On mem_ready: ir_wr = 1, pc_inc = 1, -> DECODE. Otherwise hold, with requests held stable.
  - DECODE: op_q <= opcode. Next state:
    - NOP -> FETCH.
    - HLT -> HALT.
    - LD/ADD/SUB/AND/OR/XOR -> MEM_RD.
    - ST -> MEM_WR.
    - NOT/CLR/JMP/JZ/JN/LDI/ADDI -> EXEC.
    - Illegal -> FETCH, with illegal_op = 1 this cycle.
    - NOP and illegal opcodes retire on the DECODE exit edge.
  - MEM_RD: mem_rd = 1, addr_sel = 1. On mem_ready -> EXEC. The datapath holds the operand.
  - MEM_WR: mem_wr = 1, addr_sel = 1. On mem_ready -> FETCH and retire.
  - EXEC: exactly one cycle, then -> FETCH and retire.
    - LD: acc_wr, PASS_B, opnd_sel 0.
    - ADD..XOR: acc_wr with the matching alu_op, opnd_sel 0.
    - NOT: acc_wr, NOT_A.
    - CLR: acc_reset = 1, acc_wr = 0.
    - LDI: acc_wr, PASS_B, opnd_sel 1.
    - ADDI: acc_wr, ADD, opnd_sel 1.
    - JMP: pc_load = 1.
    - JZ: pc_load = acc_zero.
    - JN: pc_load = acc_neg.
    - Flags are sampled in EXEC and reflect the accumulator before this instruction.
  - HALT: halted = 1, and HLT has retired. start -> FETCH.
    - start held high in HALT re-enters FETCH next cycle. This is by design; no edge detect.
- Mutual exclusion:
  - mem_rd and mem_wr are never high together.
  - acc_wr and acc_reset are never high together.
  - pc_inc and pc_load are never high together.
- Latency, with mem_ready always 1:
  - NOP/illegal: 2 cycles.
  - EXEC-class (NOT/CLR/JMP/JZ/JN/LDI/ADDI): 3 cycles.
  - ST: 3 cycles.
  - LD/ALU-memory: 4 cycles.
  - Each mem wait cycle adds 1.
- retired increments by 1 per instruction on the exit edge. It wraps from 2^CNT_W-1 to 0.
- start is ignored while busy.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

Test Plan:
- Reset then start, mem_ready = 1, opcode = 13 (LDI):
  - FETCH 1 cycle with ir_wr = pc_inc = 1.
  - DECODE 1 cycle.
  - EXEC: acc_wr = 1, alu_op = 0, opnd_sel = 1.
  - retired goes 0 -> 1 on the third edge.
- opcode = 3 (ADD) with mem_ready low for 3 cycles in MEM_RD:
  - mem_rd and addr_sel = 1 held for 4 cycles.
  - Then EXEC: acc_wr = 1, alu_op = 1.
  - Total 7 cycles.
- JZ with acc_zero = 1 -> pc_load = 1 in EXEC. JZ with acc_zero = 0 -> pc_load = 0, retired still increments. Repeat for JN with acc_neg.
- opcode = 20 -> illegal_op = 1 for exactly one cycle in DECODE, no acc_wr, back to FETCH, retired +1.
- opcode = 15 -> halted = 1, busy = 0, retired +1. start = 1 -> FETCH on the next edge.
- ST with reset_n pulsed low mid MEM_WR (before mem_ready):
  - mem_wr drops immediately (async); all outputs 0; state IDLE; retired = 0.
  - No fetch until start.
